// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: control-field bit map, opcodes and the
// default-width stage entry used at the core's stage boundaries.
package pipe_pkg;

   localparam int PIPE_DATA_W = 64;
   localparam int PIPE_CTRL_W = 8;

   localparam int CTRL_MEM_WRITE = 0;
   localparam int CTRL_WRITE_REG = 1;
   localparam int CTRL_MEM_READ  = 2;
   localparam int CTRL_HLT       = 3;
   localparam int CTRL_DATA_MUX  = 4;

   localparam logic [PIPE_CTRL_W-1:0] NOP_CTRL = '0;

   localparam logic [3:0] HLT_OPCODE = 4'hF;
   localparam logic [3:0] LW_OPCODE  = 4'h8;

   typedef struct packed {
      logic                   valid;
      logic [PIPE_CTRL_W-1:0] ctrl;
      logic [PIPE_DATA_W-1:0] data;
   } pipe_entry_t;

   function automatic logic is_nop(input logic [PIPE_CTRL_W-1:0] c);
      return c == NOP_CTRL;
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry, bubble
// insertion, flush and saturating stall/bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              bubble,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic              valid;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam entry_t EMPTY = '0;

   entry_t main_q;
   entry_t main_d;
   entry_t in_entry;
   entry_t nop_entry;

   logic in_fire;
   logic out_fire;
   logic main_load;
   logic skid_valid;
   logic stall_inc;
   logic bubble_inc;

   assign in_entry  = '{valid: 1'b1, ctrl: in_ctrl, data: in_data};
   assign nop_entry = '{valid: 1'b1, ctrl: '0, data: '0};

   assign in_fire   = in_valid & in_ready & ~bubble;
   assign out_fire  = main_q.valid & out_ready;
   assign main_load = ~main_q.valid | out_fire;

   generate
      if (SKID) begin : g_skid
         entry_t skid_q;
         entry_t skid_d;

         assign skid_valid = skid_q.valid;
         assign in_ready   = ~skid_q.valid & ~bubble;

         // Skid is always older than the input, so it drains first.
         always_comb begin
            main_d = main_q;
            skid_d = skid_q;
            if (flush) begin
               main_d = EMPTY;
               skid_d = EMPTY;
            end else if (main_load) begin
               skid_d = EMPTY;
               if (skid_q.valid) begin
                  main_d = skid_q;
               end else if (bubble) begin
                  main_d = nop_entry;
               end else if (in_fire) begin
                  main_d = in_entry;
               end else begin
                  main_d = EMPTY;
               end
            end else if (in_fire) begin
               skid_d = in_entry;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_q <= EMPTY;
            end else begin
               skid_q <= skid_d;
            end
         end
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign in_ready   = (~main_q.valid | out_ready) & ~bubble;

         always_comb begin
            main_d = main_q;
            if (flush) begin
               main_d = EMPTY;
            end else if (main_load) begin
               if (bubble) begin
                  main_d = nop_entry;
               end else if (in_fire) begin
                  main_d = in_entry;
               end else begin
                  main_d = EMPTY;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= EMPTY;
      end else begin
         main_q <= main_d;
      end
   end

   assign stall_inc  = main_q.valid & ~out_ready;
   assign bubble_inc = bubble & main_load & ~skid_valid & ~flush;

   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .count (bubble_cnt)
   );

   assign out_valid = main_q.valid;
   assign out_data  = main_q.data;
   assign out_ctrl  = main_q.ctrl & {CTRL_W{main_q.valid}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 instance with an ordering scoreboard,
// plus a SKID=0, CNT_W=3 instance for saturation and combinational ready.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, bubble, flush;
   logic        out_valid, out_ready;
   logic [63:0] in_data, out_data;
   logic [7:0]  in_ctrl, out_ctrl;
   logic [15:0] stall_cnt, bubble_cnt;

   logic        in_valid0, in_ready0, bubble0, flush0;
   logic        out_valid0, out_ready0;
   logic [63:0] in_data0, out_data0;
   logic [7:0]  in_ctrl0, out_ctrl0;
   logic [2:0]  stall_cnt0, bubble_cnt0;

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl),
      .bubble(bubble), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1'b0), .CNT_W(3)) dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .in_data(in_data0), .in_ctrl(in_ctrl0),
      .bubble(bubble0), .flush(flush0),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_data(out_data0), .out_ctrl(out_ctrl0),
      .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
   );

   int total = 0;
   int bad = 0;
   bit sb_on = 1'b0;
   logic [71:0] sb_q[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Inputs settle at posedge+1, so negedge sees what the next edge sees.
   always @(negedge clk) begin
      if (sb_on && !rst) begin
         if (in_valid && in_ready && !bubble && !flush)
            sb_q.push_back({in_ctrl, in_data});
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               logic [71:0] e;
               e = sb_q.pop_front();
               chk("sb_data", out_data, e[63:0]);
               chk("sb_ctrl", {56'd0, out_ctrl}, {56'd0, e[71:64]});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      in_valid = 0; in_data = '0; in_ctrl = '0;
      bubble = 0; flush = 0; out_ready = 1;
      in_valid0 = 0; in_data0 = '0; in_ctrl0 = '0;
      bubble0 = 0; flush0 = 0; out_ready0 = 1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();
      chk("init_out_ctrl", out_ctrl, 0);
      chk("init_counts", {stall_cnt, bubble_cnt}, 0);

      // streaming
      sb_on = 1;
      in_valid = 1; in_ctrl = 8'h01;
      in_data = 64'hA; cyc();
      chk("stream_a", out_data, 64'hA);
      chk("stream_rdy_a", in_ready, 1);
      in_data = 64'hB; cyc();
      chk("stream_b", out_data, 64'hB);
      in_data = 64'hC; cyc();
      chk("stream_c", out_data, 64'hC);
      chk("stream_rdy_c", in_ready, 1);
      in_valid = 0; cyc();
      chk("stream_empty", out_valid, 0);
      chk("stream_stall", stall_cnt, 0);

      // backpressure
      out_ready = 0;
      in_valid = 1; in_ctrl = 8'h02;
      in_data = 64'hA; cyc();
      chk("bp_rdy_after_a", in_ready, 1);
      in_data = 64'hB; cyc();
      chk("bp_rdy_after_b", in_ready, 0);
      in_data = 64'hC; cyc();
      chk("bp_hold_a", out_data, 64'hA);
      chk("bp_stall", stall_cnt, 2);
      out_ready = 1; cyc();
      chk("bp_out_b", out_data, 64'hB);
      chk("bp_rdy_back", in_ready, 1);
      cyc();
      chk("bp_out_c", out_data, 64'hC);
      in_valid = 0; cyc();
      chk("bp_drained", out_valid, 0);
      chk("bp_stall_hold", stall_cnt, 2);

      // bubble
      in_valid = 1; in_ctrl = 8'h03; in_data = 64'h55;
      bubble = 1;
      #1;
      chk("bub_in_ready", in_ready, 0);
      sb_q.push_back(72'd0);
      cyc();
      chk("bub_valid", out_valid, 1);
      chk("bub_ctrl", out_ctrl, 0);
      chk("bub_data", out_data, 0);
      chk("bub_cnt", bubble_cnt, 1);
      bubble = 0; cyc();
      chk("bub_next_data", out_data, 64'h55);
      chk("bub_next_ctrl", out_ctrl, 8'h03);
      in_valid = 0; cyc();
      chk("sb_left", sb_q.size(), 0);
      sb_on = 0;

      // flush with main and skid full
      out_ready = 0; in_valid = 1; in_ctrl = 8'h04;
      in_data = 64'hD; cyc();
      in_data = 64'hE; cyc();
      chk("fl_skid_full", in_ready, 0);
      in_data = 64'hF; flush = 1; cyc();
      chk("fl_valid", out_valid, 0);
      chk("fl_ctrl", out_ctrl, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_stall", stall_cnt, 4);
      chk("fl_bub", bubble_cnt, 1);
      // flush drops an entry accepted on the same cycle
      flush = 0; in_data = 64'h6; cyc();
      chk("fl_g_load", out_data, 64'h6);
      in_data = 64'h7; flush = 1;
      #1;
      chk("fl_h_fire", in_ready, 1);
      cyc();
      chk("fl_h_drop", out_valid, 0);
      chk("fl_h_stall", stall_cnt, 5);
      in_valid = 0; bubble = 1; cyc();
      chk("fl_bub_win", out_valid, 0);
      chk("fl_bub_cnt", bubble_cnt, 1);
      flush = 0; bubble = 0; out_ready = 1; cyc();
      chk("fl_still_empty", out_valid, 0);

      // SKID=0 combinational ready and saturation
      in_valid0 = 1; in_ctrl0 = 8'h11; in_data0 = 64'h77;
      out_ready0 = 0; cyc();
      in_valid0 = 0;
      chk("s0_data", out_data0, 64'h77);
      chk("s0_rdy_lo", in_ready0, 0);
      out_ready0 = 1; #1;
      chk("s0_rdy_hi", in_ready0, 1);
      out_ready0 = 0; #1;
      chk("s0_rdy_lo2", in_ready0, 0);
      repeat (10) cyc();
      chk("s0_sat", stall_cnt0, 7);
      chk("s0_ctrl", out_ctrl0, 8'h11);
      out_ready0 = 1; cyc();
      chk("s0_drain", out_valid0, 0);
      chk("s0_bub", bubble_cnt0, 0);

      // async reset mid-stream with main and skid both held
      out_ready = 0; in_valid = 1; in_ctrl = 8'h05;
      in_data = 64'h21; cyc();
      in_data = 64'h22; cyc();
      chk("rs_held", {out_valid, in_ready}, 2'b10);
      in_valid = 0;
      rst = 1; #1;
      chk("rs_valid", out_valid, 0);
      chk("rs_ctrl", out_ctrl, 0);
      chk("rs_in_ready", in_ready, 1);
      chk("rs_stall", stall_cnt, 0);
      chk("rs_bub", bubble_cnt, 0);
      cyc();
      rst = 0; out_ready = 1; cyc();
      chk("rs_after", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
